approx_mul_seq: RTL and testbench

APPROX_MUL_SEQ -- requirements
Module: approx_mul_seq

---
 rtl/approx_mul_seq.sv | 146 ++++++++++++++
 tb/tb_approx_mul_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_seq.sv
// ----------------------------------------------------------------------------
// approx_mul_seq
//
// Sequential 8x8 unsigned multiplier built around one shared external 4x4
// multiplier. The four nibble partial products are issued one per cycle and
// summed into a 16-bit accumulator. In approximate mode the low-by-low partial
// product is skipped, which saves one cycle.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : operand pair offered
//   in_ready   : operand pair accepted this cycle (IDLE only)
//   a, b       : 8-bit unsigned operands
//   approx     : 1 = omit a[3:0]*b[3:0]
//   mul_a/b    : nibbles to the external 4x4 multiplier
//   mul_en     : mul_a/mul_b carry a live step
//   mul_p      : combinational 8-bit product from the external multiplier
//   out_valid  : r holds a completed result
//   out_ready  : consumer takes r this cycle
//   r          : accumulated product
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready high
// LL    | a[3:0] * b[3:0], added unshifted
// HL    | a[7:4] * b[3:0], added << 4 (first step in approx mode)
// LH    | a[3:0] * b[7:4], added << 4
// HH    | a[7:4] * b[7:4], added << 8
// DONE  | result presented, held until out_ready
// ----------------------------------------------------------------------------
module approx_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        approx,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    output logic        mul_en,
    input  logic [7:0]  mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] r
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LL   = 3'd1,
        HL   = 3'd2,
        LH   = 3'd3,
        HH   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic        approx_q;
    logic [15:0] acc;

    // mul_a/mul_b/mul_en are registered together with the state transition,
    // so during each step they already present that step's nibbles and the
    // external multiplier's product can be accumulated at the end of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            approx_q  <= 1'b0;
            acc       <= 16'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mul_en    <= 1'b0;
            mul_a     <= 4'd0;
            mul_b     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        approx_q <= approx;
                        acc      <= 16'd0;
                        in_ready <= 1'b0;
                        mul_en   <= 1'b1;
                        mul_b    <= b[3:0];
                        if (approx) begin
                            state <= HL;
                            mul_a <= a[7:4];
                        end else begin
                            state <= LL;
                            mul_a <= a[3:0];
                        end
                    end
                end
                LL: begin
                    acc   <= acc + {8'd0, mul_p};
                    state <= HL;
                    mul_a <= a_q[7:4];
                    mul_b <= b_q[3:0];
                end
                HL: begin
                    acc   <= acc + {4'd0, mul_p, 4'd0};
                    state <= LH;
                    mul_a <= a_q[3:0];
                    mul_b <= b_q[7:4];
                end
                LH: begin
                    acc   <= acc + {4'd0, mul_p, 4'd0};
                    state <= HH;
                    mul_a <= a_q[7:4];
                    mul_b <= b_q[7:4];
                end
                HH: begin
                    acc       <= acc + {mul_p, 8'd0};
                    state     <= DONE;
                    mul_en    <= 1'b0;
                    mul_a     <= 4'd0;
                    mul_b     <= 4'd0;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    mul_en    <= 1'b0;
                    mul_a     <= 4'd0;
                    mul_b     <= 4'd0;
                end
            endcase
        end
    end

    assign r = acc;

endmodule

// File: tb/tb_approx_mul_seq.sv
module tb_approx_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        approx;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic        mul_en;
    logic [7:0]  mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r;

    int n_vec = 0;
    int n_err = 0;

    approx_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .approx    (approx),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_en    (mul_en),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r)
    );

    // shared external 4x4 multiplier
    assign mul_p = 8'(mul_a * mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input int ai, input int bi, input bit ap);
        int p;
        p = ai * bi;
        if (ap) p = p - (ai % 16) * (bi % 16);
        return 16'(p);
    endfunction

    logic [15:0] last_r;

    // One complete transaction. Inputs are scrambled after acceptance, the
    // result is held for wait_cycles in DONE, and optionally in_valid is
    // kept high during DONE to confirm nothing is accepted there.
    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input bit ap,
                          input int wait_cycles, input bit hold_valid);
        logic [15:0] exp_r;
        logic [3:0]  exp_na[4];
        logic [3:0]  exp_nb[4];
        int          first;
        int          n;
        bit          seen;
        exp_r = ref_mul(int'(ai), int'(bi), ap);
        exp_na[0] = ai[3:0]; exp_nb[0] = bi[3:0];
        exp_na[1] = ai[7:4]; exp_nb[1] = bi[3:0];
        exp_na[2] = ai[3:0]; exp_nb[2] = bi[7:4];
        exp_na[3] = ai[7:4]; exp_nb[3] = bi[7:4];
        first = ap ? 1 : 0;

        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = ai; b = bi; approx = ap;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); approx = 1'($urandom);

        seen = 1'b0;
        n = 1;
        while (n <= 8) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            if (first + n - 1 <= 3)
                check("step_mul", {23'd0, mul_en, mul_a, mul_b},
                      {23'd0, 1'b1, exp_na[first + n - 1], exp_nb[first + n - 1]});
            else
                check("step_overrun", 32'(out_valid), 32'd1);
            a = 8'($urandom); b = 8'($urandom); approx = 1'($urandom);
            @(posedge clk);
            n++;
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", 32'(n), ap ? 32'd4 : 32'd5);
        check("result", 32'(r), 32'(exp_r));
        check("done_flags", {29'd0, in_ready, mul_en, mul_a == 4'd0 && mul_b == 4'd0},
              {29'd0, 1'b0, 1'b0, 1'b1});

        in_valid = hold_valid;
        for (int k = 0; k < wait_cycles; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_done", {14'd0, out_valid, in_ready, r}, {14'd0, 1'b1, 1'b0, exp_r});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("back_idle", {14'd0, in_ready, out_valid, r}, {14'd0, 1'b1, 1'b0, exp_r});
        last_r = exp_r;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = 8'd0; b = 8'd0; approx = 1'b0; out_ready = 1'b0;
        last_r = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {11'd0, in_ready, out_valid, mul_en, mul_a, mul_b, r},
              {11'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 16'd0});

        // directed corners
        run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        run_op(8'h12, 8'h34, 1'b0, 0, 1'b0);
        run_op(8'h12, 8'h34, 1'b1, 0, 1'b0);
        run_op(8'h00, 8'hA5, 1'b0, 1, 1'b0);
        run_op(8'hC3, 8'h01, 1'b1, 0, 1'b0);

        // backpressure with in_valid held high in DONE
        run_op(8'h9B, 8'h6D, 1'b0, 3, 1'b1);

        // idle with in_valid low: nothing moves
        repeat (4) @(negedge clk);
        check("idle_hold", {15'd0, in_ready, r}, {15'd0, 1'b1, last_r});

        // reset during HL aborts the operation
        @(negedge clk);
        in_valid = 1'b1; a = 8'hEE; b = 8'h77; approx = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("in_hl", {24'd0, mul_a, mul_b}, {24'd0, 4'hE, 4'h7});
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("after_abort", {13'd0, in_ready, out_valid, mul_en, r},
              {13'd0, 1'b1, 1'b0, 1'b0, 16'd0});
        begin
            int pulses;
            pulses = 0;
            repeat (6) begin
                @(negedge clk);
                if (out_valid) pulses++;
            end
            check("no_pulse_after_abort", 32'(pulses), 32'd0);
        end
        run_op(8'h03, 8'h05, 1'b0, 0, 1'b0);

        // randomized transactions
        for (int i = 0; i < 40; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
